mem_port_requester: RTL and testbench

- Core-side initiator for the shared 8-lane RAM arbiter. One instance per core.
- Accepts single-byte read/write commands from the core over a valid/ready handshake.
- Drives its own rden/wren bit and its own byte lane of the 64-bit Address/Din buses, and waits for its acq bit.
- Captures read data from its lane of Dq, returns one response per command, then releases the bus so other cores can be granted.

---
 rtl/mem_port_requester.sv | 141 ++++++++++++++
 tb/tb_mem_port_requester.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_requester.sv
// Core-side initiator for the shared multi-lane RAM arbiter: one byte command in,
// own rden/wren bit and byte lane out, one response per command, then bus release.
module mem_port_requester #(
  parameter int NCORES  = 8,
  parameter int CORE_ID = 0,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_we,
  input  logic [7:0]        core_addr,
  input  logic [7:0]        core_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic [NCORES-1:0] rden,
  output logic [NCORES-1:0] wren,
  output logic [63:0]       Address,
  output logic [63:0]       Din,
  input  logic [NCORES-1:0] acq,
  input  logic [63:0]       Dq
);

  localparam int          LANE_LO = 8 * CORE_ID;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_REL} state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  lat_q, lat_d;
  logic        rv_q, rv_d, re_q, re_d;
  logic [7:0]  rdat_q, rdat_d;

  logic        grant;
  logic [7:0]  dq_lane;
  assign grant   = acq[CORE_ID];
  assign dq_lane = Dq[LANE_LO +: 8];

  // Other cores' grant bits and byte lanes are deliberately ignored.
  logic unused_in;
  assign unused_in = ^{acq, Dq};

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    to_cnt_d = to_cnt_q;
    lat_d    = lat_q;
    rv_d     = 1'b0;
    re_d     = 1'b0;
    rdat_d   = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (core_valid) begin
          cmd_d    = '{we: core_we, addr: core_addr, wdata: core_wdata};
          rd_d     = ~core_we;
          wr_d     = core_we;
          to_cnt_d = 16'h0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // A grant on the same edge as the timeout expiry wins.
        if (grant) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          lat_d   = 2'(RD_LAT);
          state_d = S_WAIT;
        end else if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rv_d    = 1'b1;
          re_d    = 1'b1;
          state_d = S_REL;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd1) begin
          rv_d    = 1'b1;
          rdat_d  = cmd_q.we ? 8'h00 : dq_lane;
          state_d = S_REL;
        end
        lat_d = lat_q - 2'd1;
      end
      S_REL: begin
        // Wait out the grant so a stale acq cannot satisfy the next command.
        if (!grant) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      to_cnt_q <= 16'h0;
      lat_q    <= 2'd0;
      rv_q     <= 1'b0;
      re_q     <= 1'b0;
      rdat_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      to_cnt_q <= to_cnt_d;
      lat_q    <= lat_d;
      rv_q     <= rv_d;
      re_q     <= re_d;
      rdat_q   <= rdat_d;
    end
  end

  assign core_ready = (state_q == S_IDLE);
  assign rsp_valid  = rv_q;
  assign rsp_err    = re_q;
  assign rsp_data   = rdat_q;
  assign rden       = NCORES'(rd_q) << CORE_ID;
  assign wren       = NCORES'(wr_q) << CORE_ID;
  assign Address    = 64'(cmd_q.addr) << LANE_LO;
  assign Din        = 64'(cmd_q.wdata) << LANE_LO;

endmodule

// File: tb/tb_mem_port_requester.sv
// Scoreboard bench: two requesters (cores 2 and 0) behind a fixed-priority arbiter/RAM
// model, plus a core-5 requester with a bench-driven grant for timeout cases.
module tb_mem_port_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: core 2 (RD_LAT 1), instance 1: core 0 (RD_LAT 2), instance 2: core 5 (TIMEOUT 8)
  logic        cv[3], cwe[3];
  logic [7:0]  ca[3], cw[3];
  logic        rdy[3], rv[3], re[3];
  logic [7:0]  rd[3];
  logic [7:0]  rden_o[3], wren_o[3];
  logic [63:0] addr_o[3], din_o[3];
  logic [7:0]  acq;
  logic [7:0]  acq5;
  logic [63:0] Dq = '0;
  logic        to_acq;
  assign acq5 = {2'b00, to_acq, 5'b00000};

  mem_port_requester #(.NCORES(8), .CORE_ID(2), .RD_LAT(1), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .core_valid(cv[0]), .core_ready(rdy[0]), .core_we(cwe[0]),
    .core_addr(ca[0]), .core_wdata(cw[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_err(re[0]),
    .rden(rden_o[0]), .wren(wren_o[0]), .Address(addr_o[0]), .Din(din_o[0]), .acq(acq), .Dq(Dq));

  mem_port_requester #(.NCORES(8), .CORE_ID(0), .RD_LAT(2), .TIMEOUT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .core_valid(cv[1]), .core_ready(rdy[1]), .core_we(cwe[1]),
    .core_addr(ca[1]), .core_wdata(cw[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_err(re[1]),
    .rden(rden_o[1]), .wren(wren_o[1]), .Address(addr_o[1]), .Din(din_o[1]), .acq(acq), .Dq(Dq));

  mem_port_requester #(.NCORES(8), .CORE_ID(5), .RD_LAT(1), .TIMEOUT(8)) u5 (
    .clk(clk), .rst_n(rst_n), .core_valid(cv[2]), .core_ready(rdy[2]), .core_we(cwe[2]),
    .core_addr(ca[2]), .core_wdata(cw[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_err(re[2]),
    .rden(rden_o[2]), .wren(wren_o[2]), .Address(addr_o[2]), .Din(din_o[2]), .acq(acq5), .Dq(Dq));

  // ---------------- arbiter + RAM model ----------------
  logic [7:0]  mem [256];
  int          owner, hold_cnt, hold_extra, pk;
  wire  [7:0]  req    = rden_o[0] | wren_o[0] | rden_o[1] | wren_o[1];
  wire  [7:0]  wr_all = wren_o[0] | wren_o[1];
  wire  [63:0] abus   = addr_o[0] | addr_o[1] | addr_o[2];
  wire  [63:0] dbus   = din_o[0] | din_o[1] | din_o[2];

  function automatic int pick(logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return i;
    return -1;
  endfunction
  always_comb pk = pick(req);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= -1; acq <= 8'h00; hold_cnt <= 0;
    end else begin
      for (int l = 0; l < 8; l++) Dq[8*l +: 8] <= mem[abus[8*l +: 8]];
      if (owner < 0) begin
        if (pk >= 0) begin
          owner <= pk;
          acq   <= 8'(1) << pk;
          if (wr_all[pk]) mem[abus[8*pk +: 8]] <= dbus[8*pk +: 8];
        end
      end else if (!req[owner]) begin
        if (hold_cnt >= hold_extra) begin
          acq <= 8'h00; owner <= -1; hold_cnt <= 0;
        end else hold_cnt <= hold_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] data; logic err; int acc; int lat; } exp_t;
  exp_t q0[$], q1[$], q2[$];
  logic [7:0] ref_mem [256];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(int i, output exp_t e, output bit ok);
    ok = 1'b1;
    case (i)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int idof(int i);
    return (i == 0) ? 2 : (i == 1) ? 0 : 5;
  endfunction

  // monitor: responses against scoreboard, plus lane isolation every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        bit   ok;
        logic [63:0] lm;
        lm = 64'hFF << (8 * idof(i));
        chk("rden_other_bits", {56'h0, rden_o[i] & ~(8'(1) << idof(i))}, 64'h0);
        chk("wren_other_bits", {56'h0, wren_o[i] & ~(8'(1) << idof(i))}, 64'h0);
        chk("addr_other_lanes", addr_o[i] & ~lm, 64'h0);
        chk("din_other_lanes", din_o[i] & ~lm, 64'h0);
        if (rv[i]) begin
          pop_exp(i, e, ok);
          if (!ok) chk("spurious_rsp", 64'(rv[i]), 64'h0);
          else begin
            chk("rsp_data", 64'(rd[i]), 64'(e.data));
            chk("rsp_err", 64'(re[i]), 64'(e.err));
            if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end
      end
    end
  end

  // issue one command; returns at the negedge after the accepting edge
  task automatic issue(int i, logic we, logic [7:0] a, logic [7:0] wd, logic err, int lat,
                       output int acc);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!rdy[i] && t < 300) begin @(negedge clk); t++; end
    if (!rdy[i]) begin chk("ready_wait_timeout", 64'(rdy[i]), 64'h1); acc = -1; return; end
    cv[i] = 1'b1; cwe[i] = we; ca[i] = a; cw[i] = wd;
    acc   = cyc + 1;
    e.acc = acc; e.lat = lat; e.err = err; e.data = 8'h00;
    if (!err && i != 2) begin
      if (we) ref_mem[a] = wd;
      else    e.data = ref_mem[a];
    end
    push_exp(i, e);
    @(negedge clk);
    cv[i] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 500) begin @(negedge clk); t++; end
    chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'h0);
    q0.delete(); q1.delete(); q2.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, t, n;
    for (int i = 0; i < 3; i++) begin cv[i] = 0; cwe[i] = 0; ca[i] = 0; cw[i] = 0; end
    for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; ref_mem[a] = 8'h00; end
    to_acq = 1'b0; hold_extra = 0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ready", 64'(rdy[0]), 64'h1);
    chk("rst_rden", 64'(rden_o[0]), 64'h0);
    chk("rst_wren", 64'(wren_o[0]), 64'h0);
    chk("rst_addr", addr_o[0], 64'h0);
    chk("rst_din", din_o[0], 64'h0);
    chk("rst_rsp", {rd[0], 6'h0, re[0], rv[0]}, 64'h0);
    rst_n = 1'b1;

    // 1: write 0x10 <= 0xA5
    issue(0, 1'b1, 8'h10, 8'hA5, 1'b0, 3, acc);
    chk("t1_wren", 64'(wren_o[0]), 64'h04);
    chk("t1_rden", 64'(rden_o[0]), 64'h00);
    chk("t1_addr", addr_o[0], 64'h0000_0000_0010_0000);
    chk("t1_din", din_o[0], 64'h0000_0000_00A5_0000);
    drain();

    // 2: read it back
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 3, acc);
    chk("t2_rden", 64'(rden_o[0]), 64'h04);
    drain();

    // 3: contention, core 0 wins and holds the bus
    hold_extra = 5;
    fork
      issue(1, 1'b1, 8'h41, 8'h3C, 1'b0, -1, acc1);
      issue(0, 1'b0, 8'h10, 8'h00, 1'b0, -1, acc);
    join
    n = 0;
    while (rden_o[0][2] && n < 60) begin
      chk("t3_addr_stable", 64'(addr_o[0][23:16]), 64'h10);
      n++;
      @(negedge clk);
    end
    chk("t3_stalled", 64'(n >= 7), 64'h1);
    drain();
    issue(1, 1'b0, 8'h41, 8'h00, 1'b0, -1, acc1);
    drain();

    // 5: grant lingers after completion
    hold_extra = 3;
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 3, acc);
    t = 0;
    while (!rv[0] && t < 20) begin @(negedge clk); t++; end
    n = 0;
    while (acq[2] && n < 20) begin
      chk("t5_ready_low", 64'(rdy[0]), 64'h0);
      n++;
      @(negedge clk);
    end
    chk("t5_linger_seen", 64'(n >= 2), 64'h1);
    drain();
    hold_extra = 0;

    // 4: timeout on core 5, grant-vs-timeout tie, then a further command
    issue(2, 1'b0, 8'h22, 8'h00, 1'b1, 8, acc);
    drain();
    issue(2, 1'b1, 8'h23, 8'h77, 1'b0, 9, acc);
    while (cyc < acc + 7) @(negedge clk);
    to_acq = 1'b1;
    @(negedge clk);
    to_acq = 1'b0;
    drain();
    issue(2, 1'b1, 8'h24, 8'h11, 1'b1, 8, acc);
    drain();

    // 6: reset while waiting for read data
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 3, acc);
    t = 0;
    while (!(rden_o[0] == 8'h00 && acq[2]) && t < 20) begin @(negedge clk); t++; end
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rden", 64'(rden_o[0]), 64'h0);
    chk("t6_wren", 64'(wren_o[0]), 64'h0);
    chk("t6_addr", addr_o[0], 64'h0);
    chk("t6_din", din_o[0], 64'h0);
    chk("t6_rsp", {rd[0], 6'h0, re[0], rv[0]}, 64'h0);
    chk("t6_ready", 64'(rdy[0]), 64'h1);
    q0.delete();
    @(negedge clk);
    chk("t6_no_rsp_in_reset", 64'(rv[0]), 64'h0);
    rst_n = 1'b1;
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 3, acc);
    drain();

    // randomized traffic from both arbitrated cores, disjoint address regions
    hold_extra = 1;
    fork
      for (int k = 0; k < 40; k++) begin
        int a0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(1, 1'($urandom_range(0, 1)), 8'h40 | 8'($urandom_range(0, 15)),
              8'($urandom), 1'b0, -1, a0);
      end
      for (int k = 0; k < 40; k++) begin
        int a2;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(0, 1'($urandom_range(0, 1)), 8'h10 | 8'($urandom_range(0, 15)),
              8'($urandom), 1'b0, -1, a2);
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
